// File: rtl/alu16_if.sv
// Operand/opcode request and registered result/flag response bundle for alu16.
// The execute stage drives the master side; the ALU implements the slave side.
interface alu16_if #(
    parameter int WIDTH = 16
);
    logic             en;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       opcode;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             ovf;

    modport master (
        output en, a, b, opcode,
        input  result, zero, ovf
    );

    modport slave (
        input  en, a, b, opcode,
        output result, zero, ovf
    );
endinterface

// File: rtl/alu16.sv
// Execute-stage signed ALU: one combinational function of a/b/opcode,
// captured into result/zero/ovf registers when en is high (1-cycle latency).
module alu16 #(
    parameter int WIDTH = 16
) (
    input  logic     clk,
    input  logic     rst,
    alu16_if.slave   bus
);
    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_ADDI = 3'b001,
        OP_SUBI = 3'b010,
        OP_AND  = 3'b011,
        OP_OR   = 3'b100,
        OP_XOR  = 3'b101,
        OP_SLT  = 3'b110,
        OP_NOP  = 3'b111
    } op_e;

    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             slt;
    logic             ovf_add;
    logic             ovf_sub;
    logic [WIDTH-1:0] nxt_result;
    logic             nxt_ovf;

    // ADD and ADDI share this single adder; SUBI has its own subtractor.
    assign sum  = bus.a + bus.b;
    assign diff = bus.a - bus.b;
    assign slt  = $signed(bus.a) < $signed(bus.b);

    // Signed overflow: like-signed add flips sign, or unlike-signed sub flips away from a.
    assign ovf_add = (bus.a[MSB] == bus.b[MSB]) && (sum[MSB]  != bus.a[MSB]);
    assign ovf_sub = (bus.a[MSB] != bus.b[MSB]) && (diff[MSB] != bus.a[MSB]);

    always_comb begin
        nxt_result = '0;
        nxt_ovf    = 1'b0;
        case (op_e'(bus.opcode))
            OP_ADD, OP_ADDI: begin
                nxt_result = sum;
                nxt_ovf    = ovf_add;
            end
            OP_SUBI: begin
                nxt_result = diff;
                nxt_ovf    = ovf_sub;
            end
            OP_AND:  nxt_result = bus.a & bus.b;
            OP_OR:   nxt_result = bus.a | bus.b;
            OP_XOR:  nxt_result = bus.a ^ bus.b;
            OP_SLT:  nxt_result = {{(WIDTH-1){1'b0}}, slt};
            default: nxt_result = '0;
        endcase
    end

    // zero is derived from the same next value so it always agrees with result.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.result <= '0;
            bus.zero   <= 1'b1;
            bus.ovf    <= 1'b0;
        end else if (bus.en) begin
            bus.result <= nxt_result;
            bus.zero   <= (nxt_result == '0);
            bus.ovf    <= nxt_ovf;
        end
    end
endmodule

// File: tb/tb_alu16.sv
// Directed-vector bench for alu16 with hand-computed expected values.
module tb_alu16;
    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    alu16_if #(.WIDTH(16)) bus ();

    alu16 #(.WIDTH(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic [2:0] op,
                         input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        rst        = r;
        bus.en     = e;
        bus.opcode = op;
        bus.a      = a;
        bus.b      = b;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [15:0] r,
                              input logic z, input logic o);
        chk({tag, ".result"}, {16'h0, bus.result}, {16'h0, r});
        chk({tag, ".zero"},   {31'h0, bus.zero},   {31'h0, z});
        chk({tag, ".ovf"},    {31'h0, bus.ovf},    {31'h0, o});
    endtask

    task automatic vec(input string tag, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] r, input logic z,
                       input logic o);
        drive(1'b0, 1'b1, op, a, b);
        expect_out(tag, r, z, o);
    endtask

    initial begin
        rst        = 1'b1;
        bus.en     = 1'b0;
        bus.opcode = 3'b000;
        bus.a      = '0;
        bus.b      = '0;

        drive(1'b1, 1'b0, 3'b000, 16'd0, 16'd0);
        expect_out("reset", 16'h0000, 1'b1, 1'b0);

        drive(1'b0, 1'b0, 3'b000, 16'd5, 16'd7);
        expect_out("hold_after_reset", 16'h0000, 1'b1, 1'b0);

        vec("add_10_20",     3'b000, 16'd10,     16'd20,     16'd30,     1'b0, 1'b0);
        vec("addi_m15_5",    3'b001, -16'sd15,   16'd5,      -16'sd10,   1'b0, 1'b0);
        vec("subi_30_50",    3'b010, 16'd30,     16'd50,     -16'sd20,   1'b0, 1'b0);
        vec("subi_30_m50",   3'b010, 16'd30,     -16'sd50,   16'd80,     1'b0, 1'b0);
        vec("subi_m25_m25",  3'b010, -16'sd25,   -16'sd25,   16'd0,      1'b1, 1'b0);
        vec("nop_10_m10",    3'b111, 16'd10,     -16'sd10,   16'd0,      1'b1, 1'b0);
        vec("add_ovf_pos",   3'b000, 16'h7FFF,   16'h0001,   16'h8000,   1'b0, 1'b1);
        vec("subi_ovf_neg",  3'b010, 16'h8000,   16'h0001,   16'h7FFF,   1'b0, 1'b1);
        vec("addi_ovf_neg",  3'b001, 16'h8000,   16'hFFFF,   16'h7FFF,   1'b0, 1'b1);
        vec("subi_ovf_pos",  3'b010, 16'h7FFF,   16'hFFFF,   16'h8000,   1'b0, 1'b1);
        vec("add_wrap_zero", 3'b000, 16'hFFFF,   16'h0001,   16'h0000,   1'b1, 1'b0);
        vec("and",           3'b011, 16'h00FF,   16'h0F0F,   16'h000F,   1'b0, 1'b0);
        vec("or",            3'b100, 16'h00FF,   16'h0F0F,   16'h0FFF,   1'b0, 1'b0);
        vec("xor",           3'b101, 16'h00FF,   16'h0F0F,   16'h0FF0,   1'b0, 1'b0);
        vec("xor_self_zero", 3'b101, 16'hA5A5,   16'hA5A5,   16'h0000,   1'b1, 1'b0);
        vec("slt_m5_3",      3'b110, -16'sd5,    16'd3,      16'd1,      1'b0, 1'b0);
        vec("slt_3_m5",      3'b110, 16'd3,      -16'sd5,    16'd0,      1'b1, 1'b0);
        vec("slt_eq",        3'b110, 16'd7,      16'd7,      16'd0,      1'b1, 1'b0);
        vec("and_no_ovf",    3'b011, 16'h7FFF,   16'h7FFF,   16'h7FFF,   1'b0, 1'b0);

        vec("pre_hold",      3'b000, 16'h7FFF,   16'h0001,   16'h8000,   1'b0, 1'b1);
        drive(1'b0, 1'b0, 3'b011, 16'h0000, 16'h0000);
        expect_out("hold_en0", 16'h8000, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 3'b010, 16'd3, 16'd3);
        expect_out("hold_en0_2", 16'h8000, 1'b0, 1'b1);

        drive(1'b1, 1'b1, 3'b000, 16'd1, 16'd1);
        expect_out("reset_beats_en", 16'h0000, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
